// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
// Bundles the MEM/WB write-back fields, the decode-stage read ports and the
// status outputs of wb_regfile.
//   master : pipeline/testbench side. Drives the MEM/WB fields and read selects.
//            Observes the read data, the effective write, halt and retired.
//   slave  : register file side.
// Handshake: none. The register file accepts one write-back every cycle
// (there is no valid/ready pair), and the read ports are purely combinational.
// ---------------------------------------------------------------------------
interface wb_regfile_if;
  logic        wb_regWEN;
  logic        wb_MemToReg;
  logic        wb_JType;
  logic        wb_RegDst;
  logic        wb_Halt;
  logic [4:0]  wb_rt;
  logic [4:0]  wb_rd;
  logic [31:0] wb_aluOutport;
  logic [31:0] wb_dmemload;
  logic [31:0] wb_pcplus4;
  logic [31:0] wb_instr;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic [31:0] rdat1;
  logic [31:0] rdat2;
  logic        wen_out;
  logic [4:0]  wsel_out;
  logic [31:0] wdat_out;
  logic        halt;
  logic [31:0] retired;

  modport master (
    output wb_regWEN, wb_MemToReg, wb_JType, wb_RegDst, wb_Halt,
    output wb_rt, wb_rd, wb_aluOutport, wb_dmemload, wb_pcplus4, wb_instr,
    output rsel1, rsel2,
    input  rdat1, rdat2, wen_out, wsel_out, wdat_out, halt, retired
  );

  modport slave (
    input  wb_regWEN, wb_MemToReg, wb_JType, wb_RegDst, wb_Halt,
    input  wb_rt, wb_rd, wb_aluOutport, wb_dmemload, wb_pcplus4, wb_instr,
    input  rsel1, rsel2,
    output rdat1, rdat2, wen_out, wsel_out, wdat_out, halt, retired
  );
endinterface

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back stage plus architectural register file of the pipelined MIPS
// datapath. It selects the write-back destination and data from the
// registered MEM/WB fields and writes the register array. It serves two
// combinational read ports with same-cycle write-through bypass. It also
// keeps a sticky halt flag and a retired-instruction counter.
// Ports:
//   CLK   : system clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : wb_regfile_if.slave (MEM/WB fields, read selects/data,
//           effective write wen_out/wsel_out/wdat_out, halt, retired)
// Parameters:
//   NREGS    : number of architectural registers (register 0 reads zero)
//   LINK_REG : destination of JType (jal) link writes
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int NREGS    = 32,
  parameter int LINK_REG = 31
) (
  input  logic         CLK,
  input  logic         nRST,
  wb_regfile_if.slave  bus
);

  logic [31:0] r_regs [NREGS];
  logic        r_halt;
  logic [31:0] r_retired;

  logic [4:0]  w_wsel;
  logic [31:0] w_wdat;
  logic        w_wen;
  logic [31:0] w_rdat1;
  logic [31:0] w_rdat2;

  // Destination/data selection. JType (jal) overrides both RegDst and
  // MemToReg. The effective enable is also killed by halt and by a
  // destination of register 0, so the bypass never forwards a write
  // that the array will drop.
  always_comb begin
    w_wsel = bus.wb_RegDst   ? bus.wb_rd       : bus.wb_rt;
    w_wdat = bus.wb_MemToReg ? bus.wb_dmemload : bus.wb_aluOutport;
    if (bus.wb_JType) begin
      w_wsel = 5'(LINK_REG);
      w_wdat = bus.wb_pcplus4;
    end
    w_wen = (bus.wb_regWEN | bus.wb_JType) & ~r_halt & (w_wsel != 5'd0);
  end

  // Register array. Entry 0 is only ever reset, because w_wen excludes it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wen) begin
      r_regs[w_wsel] <= w_wdat;
    end
  end

  // Halt is sticky until reset. The halt instruction itself still retires,
  // because the flag is sampled before it is set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_halt    <= 1'b0;
      r_retired <= '0;
    end else begin
      if (bus.wb_Halt) begin
        r_halt <= 1'b1;
      end
      if ((bus.wb_instr != 32'd0) && !r_halt) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  // Read ports. A same-cycle write to the selected register is forwarded.
  always_comb begin
    w_rdat1 = r_regs[bus.rsel1];
    if (bus.rsel1 == 5'd0) begin
      w_rdat1 = '0;
    end else if (w_wen && (bus.rsel1 == w_wsel)) begin
      w_rdat1 = w_wdat;
    end
  end

  always_comb begin
    w_rdat2 = r_regs[bus.rsel2];
    if (bus.rsel2 == 5'd0) begin
      w_rdat2 = '0;
    end else if (w_wen && (bus.rsel2 == w_wsel)) begin
      w_rdat2 = w_wdat;
    end
  end

  assign bus.rdat1    = w_rdat1;
  assign bus.rdat2    = w_rdat2;
  assign bus.wen_out  = w_wen;
  assign bus.wsel_out = w_wsel;
  assign bus.wdat_out = w_wdat;
  assign bus.halt     = r_halt;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Directed bench for wb_regfile. Each task drives one scenario and checks
// hand-computed values inline. Inputs change just after a rising edge and
// outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  wb_regfile_if bus ();

  wb_regfile #(.NREGS(32), .LINK_REG(31)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Watchdog: the bench only waits on its own clock, but never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.wb_regWEN     = 1'b0;
    bus.wb_MemToReg   = 1'b0;
    bus.wb_JType      = 1'b0;
    bus.wb_RegDst     = 1'b0;
    bus.wb_Halt       = 1'b0;
    bus.wb_rt         = 5'd0;
    bus.wb_rd         = 5'd0;
    bus.wb_aluOutport = 32'd0;
    bus.wb_dmemload   = 32'd0;
    bus.wb_pcplus4    = 32'd0;
    bus.wb_instr      = 32'd0;
    bus.rsel1         = 5'd0;
    bus.rsel2         = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drive_alu_write(input logic [4:0] rd, input logic [31:0] val);
    bus.wb_regWEN     = 1'b1;
    bus.wb_RegDst     = 1'b1;
    bus.wb_rd         = rd;
    bus.wb_aluOutport = val;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.rsel1 = 5'd5;
    bus.rsel2 = 5'd31;
    #2;
    checks++; if (bus.rdat1 !== 32'd0) begin errors++; $display("FAIL reset_rdat1: got %h expected %h", bus.rdat1, 32'd0); end
    checks++; if (bus.rdat2 !== 32'd0) begin errors++; $display("FAIL reset_rdat2: got %h expected %h", bus.rdat2, 32'd0); end
    checks++; if (bus.wen_out !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", bus.wen_out); end
    checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", bus.halt); end
    checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_bypass();
    clear_inputs();
    drive_alu_write(5'd5, 32'hDEADBEEF);
    bus.rsel1 = 5'd5;
    #1;
    checks++; if (bus.rdat1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rdat1: got %h expected %h", bus.rdat1, 32'hDEADBEEF); end
    checks++; if (bus.wen_out !== 1'b1) begin errors++; $display("FAIL bypass_wen: got %b expected 1", bus.wen_out); end
    checks++; if (bus.wsel_out !== 5'd5) begin errors++; $display("FAIL bypass_wsel: got %0d expected 5", bus.wsel_out); end
    checks++; if (bus.rdat2 !== 32'd0) begin errors++; $display("FAIL bypass_rdat2_r0: got %h expected %h", bus.rdat2, 32'd0); end
    tick();
    clear_inputs();
    bus.rsel1 = 5'd5;
    #1;
    checks++; if (bus.rdat1 !== 32'hDEADBEEF) begin errors++; $display("FAIL array_rdat1: got %h expected %h", bus.rdat1, 32'hDEADBEEF); end
  endtask

  task automatic test_load_jtype();
    clear_inputs();
    bus.wb_regWEN   = 1'b1;
    bus.wb_MemToReg = 1'b1;
    bus.wb_RegDst   = 1'b0;
    bus.wb_rt       = 5'd8;
    bus.wb_rd       = 5'd9;
    bus.wb_dmemload = 32'h0000_1234;
    bus.wb_aluOutport = 32'hBAD0_BAD0;
    #1;
    checks++; if (bus.wsel_out !== 5'd8) begin errors++; $display("FAIL load_wsel: got %0d expected 8", bus.wsel_out); end
    checks++; if (bus.wdat_out !== 32'h1234) begin errors++; $display("FAIL load_wdat: got %h expected %h", bus.wdat_out, 32'h1234); end
    tick();
    // JType with RegDst/MemToReg also set: link write must still win.
    clear_inputs();
    bus.wb_JType    = 1'b1;
    bus.wb_RegDst   = 1'b1;
    bus.wb_MemToReg = 1'b1;
    bus.wb_rd       = 5'd3;
    bus.wb_pcplus4  = 32'h0000_0040;
    bus.wb_dmemload = 32'h0000_9999;
    #1;
    checks++; if (bus.wen_out !== 1'b1) begin errors++; $display("FAIL jal_wen: got %b expected 1", bus.wen_out); end
    checks++; if (bus.wsel_out !== 5'd31) begin errors++; $display("FAIL jal_wsel: got %0d expected 31", bus.wsel_out); end
    checks++; if (bus.wdat_out !== 32'h40) begin errors++; $display("FAIL jal_wdat: got %h expected %h", bus.wdat_out, 32'h40); end
    tick();
    clear_inputs();
    bus.rsel1 = 5'd8;
    bus.rsel2 = 5'd31;
    #1;
    checks++; if (bus.rdat1 !== 32'h1234) begin errors++; $display("FAIL load_reg8: got %h expected %h", bus.rdat1, 32'h1234); end
    checks++; if (bus.rdat2 !== 32'h40) begin errors++; $display("FAIL jal_reg31: got %h expected %h", bus.rdat2, 32'h40); end
    bus.rsel1 = 5'd3;
    bus.rsel2 = 5'd9;
    #1;
    checks++; if (bus.rdat1 !== 32'd0) begin errors++; $display("FAIL jal_reg3_untouched: got %h expected %h", bus.rdat1, 32'd0); end
    checks++; if (bus.rdat2 !== 32'd0) begin errors++; $display("FAIL load_reg9_untouched: got %h expected %h", bus.rdat2, 32'd0); end
  endtask

  task automatic test_reg0();
    clear_inputs();
    drive_alu_write(5'd0, 32'hFFFFFFFF);
    bus.rsel1 = 5'd0;
    #1;
    checks++; if (bus.wen_out !== 1'b0) begin errors++; $display("FAIL reg0_wen: got %b expected 0", bus.wen_out); end
    checks++; if (bus.wdat_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL reg0_wdat: got %h expected %h", bus.wdat_out, 32'hFFFFFFFF); end
    checks++; if (bus.rdat1 !== 32'd0) begin errors++; $display("FAIL reg0_rdat_same: got %h expected %h", bus.rdat1, 32'd0); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.rdat1 !== 32'd0) begin errors++; $display("FAIL reg0_rdat_after: got %h expected %h", bus.rdat1, 32'd0); end
  endtask

  task automatic test_dual_read();
    clear_inputs();
    drive_alu_write(5'd7, 32'hA5A5A5A5);
    tick();
    clear_inputs();
    bus.rsel1 = 5'd7;
    bus.rsel2 = 5'd7;
    #1;
    checks++; if (bus.rdat1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL dual_old_rdat1: got %h expected %h", bus.rdat1, 32'hA5A5A5A5); end
    checks++; if (bus.rdat2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL dual_old_rdat2: got %h expected %h", bus.rdat2, 32'hA5A5A5A5); end
    drive_alu_write(5'd7, 32'h1);
    #1;
    checks++; if (bus.rdat1 !== 32'h1) begin errors++; $display("FAIL dual_byp_rdat1: got %h expected %h", bus.rdat1, 32'h1); end
    checks++; if (bus.rdat2 !== 32'h1) begin errors++; $display("FAIL dual_byp_rdat2: got %h expected %h", bus.rdat2, 32'h1); end
    tick();
    clear_inputs();
    bus.rsel1 = 5'd7;
    bus.rsel2 = 5'd7;
    #1;
    checks++; if (bus.rdat1 !== 32'h1) begin errors++; $display("FAIL dual_new_rdat1: got %h expected %h", bus.rdat1, 32'h1); end
    checks++; if (bus.rdat2 !== 32'h1) begin errors++; $display("FAIL dual_new_rdat2: got %h expected %h", bus.rdat2, 32'h1); end
  endtask

  task automatic test_halt();
    logic [31:0] exp_ret;
    do_reset();
    exp_ret = 32'd0;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      drive_alu_write(5'(10 + i), 32'h100 + 32'(i));
      bus.wb_instr = 32'h0022_1820;
      tick();
      exp_ret = exp_ret + 32'd1;
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL halt_pre_retired%0d: got %0d expected %0d", i, bus.retired, exp_ret); end
    end
    clear_inputs();
    bus.wb_Halt  = 1'b1;
    bus.wb_instr = 32'hFC00_0000;
    #1;
    checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL halt_before_edge: got %b expected 0", bus.halt); end
    tick();
    checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", bus.halt); end
    checks++; if (bus.retired !== 32'd4) begin errors++; $display("FAIL halt_retired: got %0d expected 4", bus.retired); end
    clear_inputs();
    drive_alu_write(5'd4, 32'h55);
    bus.wb_instr = 32'h0022_1820;
    bus.rsel1    = 5'd4;
    bus.rsel2    = 5'd11;
    #1;
    checks++; if (bus.wen_out !== 1'b0) begin errors++; $display("FAIL halt_wen_blocked: got %b expected 0", bus.wen_out); end
    checks++; if (bus.rdat1 !== 32'd0) begin errors++; $display("FAIL halt_no_bypass: got %h expected %h", bus.rdat1, 32'd0); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.retired !== 32'd4) begin errors++; $display("FAIL halt_frozen%0d: got %0d expected 4", i, bus.retired); end
    end
    checks++; if (bus.rdat1 !== 32'd0) begin errors++; $display("FAIL halt_reg4: got %h expected %h", bus.rdat1, 32'd0); end
    checks++; if (bus.rdat2 !== 32'h101) begin errors++; $display("FAIL halt_reg11: got %h expected %h", bus.rdat2, 32'h101); end
    checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", bus.halt); end
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      if (i % 2 == 1) begin
        drive_alu_write(5'd3, 32'h77);
        bus.wb_instr = 32'h0022_1820;
      end
      tick();
    end
    clear_inputs();
    bus.rsel1 = 5'd3;
    #1;
    checks++; if (bus.retired !== 32'd4) begin errors++; $display("FAIL bubble_retired: got %0d expected 4", bus.retired); end
    checks++; if (bus.rdat1 !== 32'h77) begin errors++; $display("FAIL bubble_reg3: got %h expected %h", bus.rdat1, 32'h77); end
    // Set halt so the mid-cycle reset has a flag to clear.
    bus.wb_Halt  = 1'b1;
    bus.wb_instr = 32'hFC00_0000;
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL bubble_halt_set: got %b expected 1", bus.halt); end
    checks++; if (bus.retired !== 32'd5) begin errors++; $display("FAIL bubble_halt_retired: got %0d expected 5", bus.retired); end
    rst_n = 1'b0;
    #0.5;
    checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL midreset_retired: got %0d expected 0", bus.retired); end
    checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL midreset_halt: got %b expected 0", bus.halt); end
    for (int r = 0; r < 32; r++) begin
      bus.rsel1 = 5'(r);
      bus.rsel2 = 5'(31 - r);
      #0.1;
      checks++; if (bus.rdat1 !== 32'd0) begin errors++; $display("FAIL midreset_rdat1_r%0d: got %h expected %h", r, bus.rdat1, 32'd0); end
      checks++; if (bus.rdat2 !== 32'd0) begin errors++; $display("FAIL midreset_rdat2_r%0d: got %h expected %h", 31 - r, bus.rdat2, 32'd0); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_bypass();
    test_load_jtype();
    test_reg0();
    test_dual_read();
    test_halt();
    test_bubbles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the pipelined MIPS datapath. Consumes the registered MEM/WB pipeline outputs and selects the write-back destination and data. Performs the register write and serves the two decode-stage read ports with same-cycle write-through bypass. Also maintains a sticky halt flag and a retired-instruction counter for the system/testbench.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired zero
- LINK_REG, 31, destination register for JType (jal) writes

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset; asynchronous, active-low
- wb_regWEN  in  1  MEM/WB register-write enable
- wb_MemToReg  in  1  1 selects wb_dmemload as write data, 0 selects wb_aluOutport
- wb_JType  in  1  link write: data wb_pcplus4, destination LINK_REG
- wb_RegDst  in  1  1 selects wb_rd, 0 selects wb_rt as destination
- wb_Halt  in  1  halt instruction has reached write-back
- wb_rt, wb_rd  in  5  register fields from MEM/WB
- wb_aluOutport, wb_dmemload, wb_pcplus4  in  32  data fields from MEM/WB
- wb_instr  in  32  instruction word from MEM/WB; zero marks a bubble
- rsel1, rsel2  in  5  decode-stage read selects
- rdat1, rdat2  out  32  read data (combinational, bypassed)
- wen_out  out  1  effective write enable this cycle, for the hazard/forwarding unit
- wsel_out  out  5  effective destination this cycle
- wdat_out  out  32  effective write data this cycle
- halt  out  1  sticky halt flag
- retired  out  32  count of retired non-bubble instructions

## Operation
- Destination: wb_JType ? LINK_REG : (wb_RegDst ? wb_rd : wb_rt).
- Data: wb_JType ? wb_pcplus4 : (wb_MemToReg ? wb_dmemload : wb_aluOutport). JType overrides MemToReg and RegDst.
- Effective enable: wen_out = (wb_regWEN | wb_JType) & !halt & (wsel_out != 0).
  - wsel_out and wdat_out always show the selected values, whatever the value of wen_out.
- Write: on a CLK rising edge with wen_out=1, reg[wsel_out] <= wdat_out.
  - reg[0] is never written and always reads 0.
- Read: rdatN = 0 if rselN == 0; else wdat_out if wen_out and rselN == wsel_out; else reg[rselN].
  - rdat1 and rdat2 resolve independently.
  - Both ports may select the same register.
- Halt: if wb_Halt=1 at a rising edge, halt <= 1. The flag stays set until nRST.
  - While halt=1, wen_out=0 and retired is frozen.
  - The halt instruction's own cycle is not blocked by the flag, because the flag is not yet set. Halt carries regWEN=0.
- Retire counter:
  - retired increments by 1 at a rising edge when wb_instr != 0 and halt=0.
  - The halt instruction itself is counted.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (nRST=0, asynchronous): all registers cleared to 0, halt=0, retired=0.
  - Outputs then settle to rdat1=rdat2=0 and wen_out=0 for any MEM/WB inputs that are all zero.
  - Reset mid-operation discards pending writes immediately, with no clock required.
- Write latency: data presented in cycle N is visible via bypass in cycle N. It is visible from the register array from cycle N+1.
- Read ports are purely combinational. No handshake; the block accepts one write-back every cycle.
- Halt asserts at the edge that samples wb_Halt. Writes presented in the following cycle are suppressed.
- A write to register 0 with regWEN=1 is a no-op: wen_out=0 and no bypass.

## Test plan
- Reset, then present regWEN=1, RegDst=1, rd=5, aluOutport=0xDEADBEEF, rsel1=5 in the same cycle.
  - Required: rdat1=0xDEADBEEF combinationally (bypass).
  - Required next cycle, with regWEN=0: rdat1 is still 0xDEADBEEF.
- Load then JType: MemToReg=1, RegDst=0, rt=8, dmemload=0x1234 writes reg8=0x1234. Next, JType=1, pcplus4=0x0040, rd=3.
  - Required: reg31=0x0040 and reg3 unchanged.
  - Required: rsel1=8 gives 0x1234 and rsel2=31 gives 0x0040.
- Register 0: regWEN=1, rd=0, RegDst=1, aluOutport=0xFFFFFFFF.
  - Required: wen_out=0, and rdat1=0 with rsel1=0 both in that cycle and after.
- Halt: three nonzero instructions, then Halt=1 with instr=0xFC000000, then regWEN=1 to rd=4 with 0x55.
  - Required: retired=4 and halt=1.
  - Required: reg4 stays 0, and retired stays 4 over 10 further cycles.
- Bubbles: alternate wb_instr=0 and 0x00221820 (add $3,$1,$2) for 8 cycles.
  - Required: retired=4.
  - Then assert nRST low mid-cycle. Required: retired=0, halt=0, and all registers read 0 before the next CLK edge.
- Dual read: reg7=0xA5A5A5A5 is written. Then rsel1=rsel2=7 while a write of 0x1 to reg7 is in progress.
  - Required: both ports read 0x1 that cycle.
